// File: rtl/lb_arbiter2.sv
// Two-master local-bus arbiter: port A (gateway, never stalls) has absolute priority over port B.
// Reads are tagged through a read_pipe_len-deep pipe so returned data reaches the issuing port.
module lb_arbiter2 #(
  parameter int unsigned read_pipe_len = 3,
  parameter int unsigned aw            = 24,
  parameter int unsigned dw            = 32
) (
  input  logic          clk,
  input  logic          reset,
  // port A
  input  logic [aw-1:0] a_addr,
  input  logic          a_strobe,
  input  logic          a_rd,
  input  logic [dw-1:0] a_data_out,
  output logic [dw-1:0] a_data_in,
  // port B
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [aw-1:0] b_addr,
  input  logic          b_rd,
  input  logic [dw-1:0] b_wdata,
  output logic          b_rd_valid,
  output logic [dw-1:0] b_rd_data,
  // local bus
  output logic [aw-1:0] lb_addr,
  output logic          lb_strobe,
  output logic          lb_rd,
  output logic          lb_write,
  output logic [dw-1:0] lb_data_out,
  input  logic [dw-1:0] lb_data_in,
  output logic [15:0]   b_stall_count
);

  localparam logic OwnerA = 1'b0;
  localparam logic OwnerB = 1'b1;

  logic [aw-1:0]            r_addr;
  logic                     r_strobe;
  logic                     r_rd;
  logic [dw-1:0]            r_wdata;
  logic                     r_owner;
  logic [read_pipe_len-1:0] r_tag_v;
  logic [read_pipe_len-1:0] r_tag_own;
  logic                     r_rd_valid;
  logic [dw-1:0]            r_rd_data;
  logic [15:0]              r_stall;

  logic w_b_accept;
  logic w_b_stall;
  logic w_cap_b;

  assign w_b_accept = b_valid & ~a_strobe;
  assign w_b_stall  = b_valid & a_strobe;
  assign w_cap_b    = r_tag_v[read_pipe_len-1] & (r_tag_own[read_pipe_len-1] == OwnerB);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_strobe <= 1'b0;
      r_rd     <= 1'b0;
      r_wdata  <= '0;
      r_owner  <= OwnerA;
    end else if (a_strobe) begin
      r_addr   <= a_addr;
      r_strobe <= 1'b1;
      r_rd     <= a_rd;
      r_wdata  <= a_data_out;
      r_owner  <= OwnerA;
    end else if (w_b_accept) begin
      r_addr   <= b_addr;
      r_strobe <= 1'b1;
      r_rd     <= b_rd;
      r_wdata  <= b_wdata;
      r_owner  <= OwnerB;
    end else begin
      r_strobe <= 1'b0;
    end
  end

  // Stage k holds the tag of the read whose strobe was k+1 cycles ago.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_v   <= '0;
      r_tag_own <= '0;
    end else begin
      r_tag_v[0]   <= r_strobe & r_rd;
      r_tag_own[0] <= r_owner;
      for (int unsigned i = 1; i < read_pipe_len; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_own[i] <= r_tag_own[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_cap_b;
      if (w_cap_b) begin
        r_rd_data <= lb_data_in;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
    end else if (w_b_stall && (r_stall != 16'hffff)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign b_ready       = ~a_strobe;
  assign a_data_in     = lb_data_in;
  assign lb_addr       = r_addr;
  assign lb_strobe     = r_strobe;
  assign lb_rd         = r_rd;
  assign lb_write      = r_strobe & ~r_rd;
  assign lb_data_out   = r_wdata;
  assign b_rd_valid    = r_rd_valid;
  assign b_rd_data     = r_rd_data;
  assign b_stall_count = r_stall;

endmodule

// File: tb/tb_lb_arbiter2.sv
// Scoreboard bench for lb_arbiter2: expected bus ops and read returns are queued at drive time
// and compared when the DUT presents them.
module tb_lb_arbiter2;

  localparam int RPL = 3;
  localparam logic [31:0] Key = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] a_addr = '0;
  logic        a_strobe = 1'b0;
  logic        a_rd = 1'b0;
  logic [31:0] a_data_out = '0;
  logic [31:0] a_data_in;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [23:0] b_addr = '0;
  logic        b_rd = 1'b0;
  logic [31:0] b_wdata = '0;
  logic        b_rd_valid;
  logic [31:0] b_rd_data;
  logic [23:0] lb_addr;
  logic        lb_strobe;
  logic        lb_rd;
  logic        lb_write;
  logic [31:0] lb_data_out;
  logic [31:0] lb_data_in;
  logic [15:0] b_stall_count;

  lb_arbiter2 #(.read_pipe_len(RPL), .aw(24), .dw(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_addr       (a_addr),
    .a_strobe     (a_strobe),
    .a_rd         (a_rd),
    .a_data_out   (a_data_out),
    .a_data_in    (a_data_in),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_addr       (b_addr),
    .b_rd         (b_rd),
    .b_wdata      (b_wdata),
    .b_rd_valid   (b_rd_valid),
    .b_rd_data    (b_rd_data),
    .lb_addr      (lb_addr),
    .lb_strobe    (lb_strobe),
    .lb_rd        (lb_rd),
    .lb_write     (lb_write),
    .lb_data_out  (lb_data_out),
    .lb_data_in   (lb_data_in),
    .b_stall_count(b_stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] addr;
    logic        rd;
    logic [31:0] data;
    int          due;
  } op_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } ret_t;

  op_t  op_q[$];
  ret_t a_q[$];
  ret_t b_q[$];

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  logic [15:0] exp_stall = '0;

  // Bus model: data is only meaningful in the capture cycle, garbage otherwise.
  logic [RPL-1:0] bm_v = '0;
  logic [23:0]    bm_a [RPL];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    bm_v[0]  <= lb_strobe & lb_rd;
    bm_a[0]  <= lb_addr;
    for (int i = 1; i < RPL; i++) begin
      bm_v[i] <= bm_v[i-1];
      bm_a[i] <= bm_a[i-1];
    end
  end

  assign lb_data_in = bm_v[RPL-1] ? ({8'h00, bm_a[RPL-1]} ^ Key) : 32'hDEADBEEF;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every queued expectation is compared in exactly its due cycle.
  op_t  mo;
  ret_t mr;
  always @(negedge clk) begin
    if (!reset) begin
      if (lb_write) wr_cnt <= wr_cnt + 1;
      if (op_q.size() > 0 && op_q[0].due == cyc) begin
        mo = op_q.pop_front();
        check_val("lb_strobe", {31'd0, lb_strobe}, 32'd1);
        check_val("lb_addr", {8'd0, lb_addr}, {8'd0, mo.addr});
        check_val("lb_rd", {31'd0, lb_rd}, {31'd0, mo.rd});
        check_val("lb_write", {31'd0, lb_write}, {31'd0, ~mo.rd});
        check_val("lb_data_out", lb_data_out, mo.data);
      end else if (lb_strobe) begin
        check_val("lb_spurious", {31'd0, lb_strobe}, 32'd0);
      end
      if (b_q.size() > 0 && b_q[0].due == cyc) begin
        mr = b_q.pop_front();
        check_val("b_rd_valid", {31'd0, b_rd_valid}, 32'd1);
        check_val("b_rd_data", b_rd_data, mr.data);
      end else if (b_rd_valid) begin
        check_val("b_rd_spurious", {31'd0, b_rd_valid}, 32'd0);
      end
      if (a_q.size() > 0 && a_q[0].due == cyc) begin
        mr = a_q.pop_front();
        check_val("a_data_in", a_data_in, mr.data);
      end
    end
  end

  task automatic drive(input logic as, input logic ar, input logic [23:0] aa, input logic [31:0] ad,
                       input logic bv, input logic br, input logic [23:0] ba,
                       input logic [31:0] bd);
    int k;
    @(posedge clk);
    #1;
    a_strobe = as; a_rd = ar; a_addr = aa; a_data_out = ad;
    b_valid = bv; b_rd = br; b_addr = ba; b_wdata = bd;
    k = cyc;
    if (as) begin
      op_q.push_back('{addr: aa, rd: ar, data: ad, due: k + 1});
      if (ar) a_q.push_back('{data: {8'd0, aa} ^ Key, due: k + 1 + RPL});
      if (bv && exp_stall != 16'hffff) exp_stall++;
    end else if (bv) begin
      op_q.push_back('{addr: ba, rd: br, data: bd, due: k + 1});
      if (br) b_q.push_back('{data: {8'd0, ba} ^ Key, due: k + 2 + RPL});
    end
    #1;
    check_val("b_ready", {31'd0, b_ready}, {31'd0, ~as});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 24'h0, 32'h0, 1'b0, 1'b0, 24'h0, 32'h0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_lb_strobe"}, {31'd0, lb_strobe}, 32'd0);
    check_val({tag, "_lb_addr"}, {8'd0, lb_addr}, 32'd0);
    check_val({tag, "_lb_rd"}, {31'd0, lb_rd}, 32'd0);
    check_val({tag, "_lb_data_out"}, lb_data_out, 32'd0);
    check_val({tag, "_b_rd_valid"}, {31'd0, b_rd_valid}, 32'd0);
    check_val({tag, "_b_rd_data"}, b_rd_data, 32'd0);
    check_val({tag, "_stall"}, {16'd0, b_stall_count}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("rst");
    reset = 1'b0;
    idle(2);

    // B alone: read 0x10 returns 0xA5A5A5B5 five cycles after accept.
    drive(1'b0, 1'b0, 24'h0, 32'h0, 1'b1, 1'b1, 24'h000010, 32'h0);
    idle(8);

    // Conflict: A write wins, B read issues the following cycle.
    drive(1'b1, 1'b0, 24'h000004, 32'h12345678, 1'b1, 1'b1, 24'h000008, 32'h0);
    drive(1'b0, 1'b0, 24'h0, 32'h0, 1'b1, 1'b1, 24'h000008, 32'h0);
    idle(1);
    check_val("stall_after_conflict", {16'd0, b_stall_count}, 32'd1);
    idle(7);

    // Interleave A/B/A reads.
    drive(1'b1, 1'b1, 24'h000020, 32'h0, 1'b0, 1'b0, 24'h0, 32'h0);
    drive(1'b0, 1'b0, 24'h0, 32'h0, 1'b1, 1'b1, 24'h000030, 32'h0);
    drive(1'b1, 1'b1, 24'h000040, 32'h0, 1'b0, 1'b0, 24'h0, 32'h0);
    idle(8);
    check_val("b_rd_hold", b_rd_data, 32'hA5A5A595);

    // Four back-to-back B writes.
    wr_cnt = 0;
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b0, 24'h0, 32'h0, 1'b1, 1'b0, 24'h000100 + 24'(i), 32'hC0DE0000 + 32'(i));
    idle(8);
    check_val("write_pulses", 32'(wr_cnt), 32'd4);
    check_val("b_rd_hold_wr", b_rd_data, 32'hA5A5A595);

    // Reset two cycles after a B read is accepted; outputs clear asynchronously.
    drive(1'b0, 1'b0, 24'h0, 32'h0, 1'b1, 1'b1, 24'h000050, 32'h0);
    idle(1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    op_q.delete();
    a_q.delete();
    b_q.delete();
    exp_stall = '0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    idle(12);

    // Starvation: A strobes continuously while B waits with a read.
    for (int i = 0; i < 70000; i++)
      drive(1'b1, 1'b0, 24'(i), 32'(i), 1'b1, 1'b1, 24'h000055, 32'h0);
    idle(1);
    check_val("stall_sat", {16'd0, b_stall_count}, 32'h0000ffff);
    check_val("stall_model", {16'd0, b_stall_count}, {16'd0, exp_stall});
    idle(10);

    check_val("op_q_drained", 32'(op_q.size()), 32'd0);
    check_val("a_q_drained", 32'(a_q.size()), 32'd0);
    check_val("b_q_drained", 32'(b_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
